// File: rtl/chooser_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin arbiter: FSM states,
// one-hot grant codes and the default data width.
package chooser_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  localparam int DEFAULT_WIDTH = 4;

  // Grant is a pure decode of the state register.
  function automatic logic [1:0] grant_of(input state_e st);
    logic [1:0] g;
    g = GNT_NONE;
    case (st)
      ST_GNT_A: g = GNT_A;
      ST_GNT_B: g = GNT_B;
      default:  g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/chooser.sv
// Existing 4-bit 2:1 select: y follows a when s=0, b when s=1.
module chooser (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       s,
  output logic [3:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/chooser_arbiter.sv
// Round-robin arbiter sharing one 2:1 data path between requesters A and B,
// with bounded bursts and a single registered valid/ready output stage.
module chooser_arbiter
  import chooser_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       gnt
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;   // 1 = B was served last
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;

  logic               load_en;
  logic               sel;
  logic [WIDTH-1:0]   mux_y;
  logic               beat_a, beat_b, beat_any;
  logic               cur_valid, cur_beat, oth_valid, rel;
  state_e             other_state;

  assign load_en = !out_valid_q || out_ready;
  assign sel     = (state_q == ST_GNT_B);

  assign a_ready = (state_q == ST_GNT_A) && load_en;
  assign b_ready = (state_q == ST_GNT_B) && load_en;

  assign beat_a   = a_valid && a_ready;
  assign beat_b   = b_valid && b_ready;
  assign beat_any = beat_a || beat_b;

  assign gnt       = grant_of(state_q);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  generate
    if (WIDTH == 4) begin : g_chooser
      chooser u_chooser (
        .a (a_data),
        .b (b_data),
        .s (sel),
        .y (mux_y)
      );
    end else begin : g_generic_sel
      assign mux_y = sel ? b_data : a_data;
    end
  endgenerate

  // Views of the currently granted requester, so both grant states share one path.
  assign cur_valid   = sel ? b_valid : a_valid;
  assign cur_beat    = sel ? beat_b  : beat_a;
  assign oth_valid   = sel ? a_valid : b_valid;
  assign other_state = sel ? ST_GNT_A : ST_GNT_B;
  assign rel         = !cur_valid || (cur_beat && (cnt_q == CNT_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (a_valid && b_valid) begin
          state_d = last_q ? ST_GNT_A : ST_GNT_B;
        end else if (a_valid) begin
          state_d = ST_GNT_A;
        end else if (b_valid) begin
          state_d = ST_GNT_B;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        if (!rel) begin
          if (cur_beat) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d  = '0;
          last_d = sel;
          if (oth_valid) begin
            state_d = other_state;
          end else if (cur_valid) begin
            state_d = state_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Output stage: load on any accepted beat, otherwise drain when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (beat_any) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_y;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chooser_arbiter.sv
// Directed, table-driven bench for chooser_arbiter (WIDTH=4, MAX_BURST=4),
// plus a hand-written asynchronous-reset sequence.
module tb_chooser_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid, out_ready;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid;
  logic [3:0] out_data;
  logic [1:0] gnt;

  int checks;
  int failures;

  typedef struct {
    logic       av;
    logic [3:0] ad;
    logic       bv;
    logic [3:0] bd;
    logic       orr;
    logic [1:0] gnt;
    logic       ar;
    logic       br;
    logic       ov;
    logic [3:0] od;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  chooser_arbiter #(
    .WIDTH     (4),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic av, input int ad, input logic bv, input int bd, input logic orr,
                     input logic [1:0] g, input logic ar, input logic br, input logic ov,
                     input int od, input int cnt);
    vec_t v;
    v.av = av; v.ad = 4'(ad); v.bv = bv; v.bd = 4'(bd); v.orr = orr;
    v.gnt = g; v.ar = ar; v.br = br; v.ov = ov; v.od = 4'(od); v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string tag, input int idx, input logic [1:0] g, input logic ar,
                           input logic br, input logic ov, input logic [3:0] od, input int cnt);
    chk({tag, "_gnt"}, idx, 32'(gnt), 32'(g));
    chk({tag, "_a_ready"}, idx, 32'(a_ready), 32'(ar));
    chk({tag, "_b_ready"}, idx, 32'(b_ready), 32'(br));
    chk({tag, "_out_valid"}, idx, 32'(out_valid), 32'(ov));
    chk({tag, "_out_data"}, idx, 32'(out_data), 32'(od));
    chk({tag, "_cnt"}, idx, 32'(dut.cnt_q), 32'(cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // A alone: grant at cycle 1, first output at cycle 2, cnt wraps 0..3
    add(1,  3, 0,  0, 1, 2'b00, 0, 0, 0,  0, 0);
    add(1,  3, 0,  0, 1, 2'b01, 1, 0, 0,  0, 0);
    add(1,  5, 0,  0, 1, 2'b01, 1, 0, 1,  3, 1);
    add(1,  6, 0,  0, 1, 2'b01, 1, 0, 1,  5, 2);
    add(1,  7, 0,  0, 1, 2'b01, 1, 0, 1,  6, 3);
    add(1,  8, 0,  0, 1, 2'b01, 1, 0, 1,  7, 0);
    add(1,  9, 0,  0, 1, 2'b01, 1, 0, 1,  8, 1);
    add(1, 10, 0,  0, 1, 2'b01, 1, 0, 1,  9, 2);
    add(1, 11, 0,  0, 1, 2'b01, 1, 0, 1, 10, 3);
    add(1, 12, 0,  0, 1, 2'b01, 1, 0, 1, 11, 0);
    // both valid: A finishes its burst, then four B beats, then A, no bubbles
    add(1,  1, 1,  9, 1, 2'b01, 1, 0, 1, 12, 1);
    add(1,  2, 1,  9, 1, 2'b01, 1, 0, 1,  1, 2);
    add(1,  3, 1,  9, 1, 2'b01, 1, 0, 1,  2, 3);
    add(1,  4, 1,  9, 1, 2'b10, 0, 1, 1,  3, 0);
    add(1,  4, 1, 10, 1, 2'b10, 0, 1, 1,  9, 1);
    add(1,  4, 1, 11, 1, 2'b10, 0, 1, 1, 10, 2);
    add(1,  4, 1, 12, 1, 2'b10, 0, 1, 1, 11, 3);
    add(1,  4, 1, 13, 1, 2'b01, 1, 0, 1, 12, 0);
    add(1,  5, 1, 13, 1, 2'b01, 1, 0, 1,  4, 1);
    // backpressure for three cycles, then release
    add(1,  6, 1, 13, 0, 2'b01, 0, 0, 1,  5, 2);
    add(1,  6, 1, 13, 0, 2'b01, 0, 0, 1,  5, 2);
    add(1,  6, 1, 13, 0, 2'b01, 0, 0, 1,  5, 2);
    add(1,  6, 1, 13, 1, 2'b01, 1, 0, 1,  5, 2);
    add(1,  7, 1, 13, 1, 2'b01, 1, 0, 1,  6, 3);
    add(1,  8, 1, 13, 1, 2'b10, 0, 1, 1,  7, 0);
    add(1,  8, 1, 14, 1, 2'b10, 0, 1, 1, 13, 1);
    add(1,  8, 1, 15, 1, 2'b10, 0, 1, 1, 14, 2);
    add(1,  8, 1,  0, 1, 2'b10, 0, 1, 1, 15, 3);
    // A takes two beats then drops valid: grant moves to B
    add(1,  8, 1,  1, 1, 2'b01, 1, 0, 1,  0, 0);
    add(1,  9, 1,  1, 1, 2'b01, 1, 0, 1,  8, 1);
    add(0,  0, 1,  1, 1, 2'b01, 1, 0, 1,  9, 2);
    add(0,  0, 1,  1, 1, 2'b10, 0, 1, 0,  9, 0);
    add(0,  0, 1,  2, 1, 2'b10, 0, 1, 1,  1, 1);
    // everyone drops: back to idle, then a tie goes to A since B was last
    add(0,  0, 0,  0, 1, 2'b10, 0, 1, 1,  2, 2);
    add(0,  0, 0,  0, 1, 2'b00, 0, 0, 0,  2, 0);
    add(1,  3, 1,  4, 1, 2'b00, 0, 0, 0,  2, 0);
    add(1,  3, 1,  4, 1, 2'b01, 1, 0, 0,  2, 0);

    rst = 1'b1;
    a_valid = 1'b1; a_data = 4'd0;
    b_valid = 1'b0; b_data = 4'd0;
    out_ready = 1'b0;
    #1;
    check_all("reset", 0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_held_gnt", 0, 32'(gnt), 32'(2'b00));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      a_valid   = vecs[i].av;
      a_data    = vecs[i].ad;
      b_valid   = vecs[i].bv;
      b_data    = vecs[i].bd;
      out_ready = vecs[i].orr;
      #1;
      check_all("vec", i, vecs[i].gnt, vecs[i].ar, vecs[i].br, vecs[i].ov, vecs[i].od, vecs[i].cnt);
      @(posedge clk);
      #1;
    end

    // mid-burst asynchronous reset with a beat sitting in the output register
    a_valid = 1'b1; a_data = 4'd3;
    b_valid = 1'b1; b_data = 4'd4;
    out_ready = 1'b0;
    #1;
    check_all("pre_rst", 0, 2'b01, 1'b0, 1'b0, 1'b1, 4'd3, 1);
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_idle_gnt", 0, 32'(gnt), 32'(2'b00));
    @(posedge clk);
    #1;
    chk("post_rst_tie_gnt", 0, 32'(gnt), 32'(2'b01));
    chk("post_rst_a_ready", 0, 32'(a_ready), 32'(1'b1));
    chk("post_rst_b_ready", 0, 32'(b_ready), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
